stim_sig_unit: RTL and testbench

Self-checking stimulus/response stage wrapped around a small combinational netlist under test (3 inputs, 3 outputs). It drives an exhaustive binary-count sequence of input vectors and waits a programmable settle time per vector. It then samples the netlist outputs and compacts them into a multiple-input signature register (MISR). At the end of the run it raises `done`, presents the final signature and, optionally, a pass flag.

---
 rtl/stim_sig_unit.sv | 134 +++++++++++++
 tb/tb_stim_sig_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/stim_sig_unit.sv
// Exhaustive-count stimulus driver with MISR response compaction around a small combinational netlist.
// Latency: NUM_VEC*(SETTLE+1) cycles from accepted start to done; no backpressure, start is ignored while busy.
// Optional signature comparator on pass is compiled in with STIM_SIG_CMP_EN.
module stim_sig_unit #(
    parameter int              VEC_W   = 3,
    parameter int              RESP_W  = 3,
    parameter int              SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021,
    parameter logic [SIG_W-1:0] SEED   = 16'hFFFF,
    parameter int              NUM_VEC = 8,
    parameter int              SETTLE  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [RESP_W-1:0] resp,
    input  logic [SIG_W-1:0]  exp_sig,
    output logic [VEC_W-1:0]  stim,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic              pass
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam state_t   FIRST_ST = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
    localparam logic [7:0]  SETTLE_LD = 8'(SETTLE);
    localparam logic [15:0] LAST_IDX  = 16'(NUM_VEC - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   stim_q, stim_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [15:0]        idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [SIG_W-1:0]   misr_nxt;
    logic               cmp_hit;

    assign misr_nxt = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(resp);

`ifdef STIM_SIG_CMP_EN
    // Compare the value being written so pass lands on the same edge as done.
    assign cmp_hit = (misr_nxt == exp_sig);
`else
    logic unused_exp_sig;
    assign unused_exp_sig = ^exp_sig;
    assign cmp_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = FIRST_ST;
                    stim_d  = '0;
                    idx_d   = '0;
                    sig_d   = SEED;
                    cnt_d   = SETTLE_LD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                sig_d = misr_nxt;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = cmp_hit;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    stim_d  = stim_q + 1'b1;
                    cnt_d   = SETTLE_LD;
                    state_d = FIRST_ST;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_stim_sig_unit.sv
// Directed bench for stim_sig_unit: three instances cover single-vector, constant-response and default configs.
// Expected signatures are hand-computed from the MISR definition.
module tb_stim_sig_unit;

`ifdef STIM_SIG_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    // Signature after each vector of the default run with resp = ~stim, seed FFFF, poly 1021.
    localparam logic [15:0] SIG_TAB [8] = '{16'hEFD8, 16'hCF97, 16'h8F0A, 16'h0E31,
                                            16'h1C61, 16'h38C0, 16'h7181, 16'hE302};

    logic clk, rst_n;
    int   n_chk, n_err;

    logic        start1, start2, start3;
    logic [2:0]  resp1, resp2, resp3;
    logic [15:0] exp_sig1, exp_sig2, exp_sig3;
    logic [2:0]  stim1, stim2, stim3;
    logic        busy1, busy2, busy3, done1, done2, done3, pass1, pass2, pass3;
    logic [15:0] sig1, sig2, sig3;

    assign resp1 = 3'b000;
    assign resp2 = 3'b001;
    assign resp3 = ~stim3;

    stim_sig_unit #(.NUM_VEC(1), .SETTLE(0)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start1), .resp(resp1), .exp_sig(exp_sig1),
        .stim(stim1), .busy(busy1), .done(done1), .signature(sig1), .pass(pass1));

    stim_sig_unit #(.SEED(16'h0000), .NUM_VEC(2), .SETTLE(0)) u_two (
        .clk(clk), .rst_n(rst_n), .start(start2), .resp(resp2), .exp_sig(exp_sig2),
        .stim(stim2), .busy(busy2), .done(done2), .signature(sig2), .pass(pass2));

    stim_sig_unit u_dflt (
        .clk(clk), .rst_n(rst_n), .start(start3), .resp(resp3), .exp_sig(exp_sig3),
        .stim(stim3), .busy(busy3), .done(done3), .signature(sig3), .pass(pass3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_dflt(input logic [15:0] es, input bit poke, input bit hold);
        int busy_cnt;
        busy_cnt = 0;
        exp_sig3 = es;
        start3   = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            tick();
            if (!hold) start3 = poke && (c == 2);
            check("dflt_stim", 32'(stim3), 32'((c / 2 > 7) ? 7 : c / 2));
            check("dflt_sig", 32'(sig3), 32'((c < 2) ? 16'hFFFF : SIG_TAB[(c < 2) ? 0 : c / 2 - 1]));
            check("dflt_busy", 32'(busy3), 32'(c < 16));
            check("dflt_done", 32'(done3), 32'(c == 16));
            if (busy3) busy_cnt++;
        end
        check("dflt_busy_cycles", 32'(busy_cnt), 32'd16);
        check("dflt_pass", 32'(pass3), 32'(CMP && (es == 16'hE302)));
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start1   = 1'b0;
        start2   = 1'b0;
        start3   = 1'b0;
        exp_sig1 = 16'hEFDF;
        exp_sig2 = 16'h0000;
        exp_sig3 = 16'hE302;

        #2;
        check("rst_stim", 32'(stim3), 32'd0);
        check("rst_sig", 32'(sig3), 32'd0);
        check("rst_busy", 32'(busy3), 32'd0);
        check("rst_done", 32'(done3), 32'd0);
        check("rst_pass", 32'(pass3), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Single vector, no settle: done one edge after start.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("one_busy", 32'(busy1), 32'd1);
        check("one_sig_seed", 32'(sig1), 32'hFFFF);
        check("one_done0", 32'(done1), 32'd0);
        tick();
        check("one_done", 32'(done1), 32'd1);
        check("one_busy_fall", 32'(busy1), 32'd0);
        check("one_sig", 32'(sig1), 32'hEFDF);
        check("one_stim", 32'(stim1), 32'd0);
        check("one_pass", 32'(pass1), 32'(CMP));

        // Zero seed, constant response 001.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("two_sig_seed", 32'(sig2), 32'h0000);
        tick();
        check("two_sig_v0", 32'(sig2), 32'h0001);
        check("two_stim_v1", 32'(stim2), 32'd1);
        check("two_done_early", 32'(done2), 32'd0);
        tick();
        check("two_sig_v1", 32'(sig2), 32'h0003);
        check("two_done", 32'(done2), 32'd1);
        check("two_busy", 32'(busy2), 32'd0);
        check("two_pass", 32'(pass2), 32'd0);

        // Default config: matching signature, off-by-one with a mid-run start pulse, then held start.
        run_dflt(16'hE302, 1'b0, 1'b0);
        run_dflt(16'hE303, 1'b1, 1'b0);
        run_dflt(16'hE302, 1'b0, 1'b1);
        tick();
        start3 = 1'b0;
        check("restart_busy", 32'(busy3), 32'd1);
        check("restart_done", 32'(done3), 32'd0);
        check("restart_sig", 32'(sig3), 32'hFFFF);
        check("restart_stim", 32'(stim3), 32'd0);
        check("restart_pass", 32'(pass3), 32'd0);

        // Abort mid-run: outputs clear without a clock edge.
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_stim", 32'(stim3), 32'd0);
        check("abort_sig", 32'(sig3), 32'd0);
        check("abort_busy", 32'(busy3), 32'd0);
        check("abort_done", 32'(done3), 32'd0);
        check("abort_pass", 32'(pass3), 32'd0);
        rst_n = 1'b1;
        run_dflt(16'hE302, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
